// File: rtl/fp32_pkg.sv
// Shared constants and types for the fp32 conversion units.
package fp32_pkg;

  localparam int unsigned EWIDTH = 8;
  localparam int unsigned MWIDTH = 23;
  localparam int unsigned BIAS   = 127;
  localparam int unsigned CNT_W  = 5;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    DONE
  } cvt_state_t;

endpackage

// File: rtl/fp32_unpack.sv
// Splits an fp32 operand into fields and classifies it for integer conversion.
module fp32_unpack
  import fp32_pkg::*;
#(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned P_EW    = 8,
  parameter int unsigned P_MW    = 23,
  parameter int unsigned P_BIAS  = 127
) (
  input  logic [DWIDTH-1:0] a_operand,
  output logic              o_sign,
  output logic [P_EW-1:0]   o_exp,
  output logic [P_MW-1:0]   o_man,
  output logic              o_is_nan_inf,
  output logic              o_is_zero_denorm,
  output logic              o_is_ovf,
  output logic              o_is_int_min,
  output logic              o_is_small,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_dir
);

  logic signed [P_EW+1:0] w_e;
  logic signed [P_EW+1:0] w_diff;

  assign o_sign = a_operand[DWIDTH-1];
  assign o_exp  = a_operand[P_MW +: P_EW];
  assign o_man  = a_operand[P_MW-1:0];

  assign w_e    = $signed({2'b00, o_exp}) - (P_EW+2)'(P_BIAS);
  assign w_diff = w_e - (P_EW+2)'(23);

  assign o_is_nan_inf     = (o_exp == '1);
  assign o_is_zero_denorm = (o_exp == '0);
  assign o_is_ovf         = !o_is_nan_inf && (w_e >= (P_EW+2)'(31));
  // -2^31 is the one e=31 value that is exactly representable
  assign o_is_int_min     = o_sign && (w_e == (P_EW+2)'(31)) && (o_man == '0);
  assign o_is_small       = (w_e <= -(P_EW+2)'(2));

  assign o_dir = (w_diff > (P_EW+2)'(0));
  assign o_cnt = CNT_W'(o_dir ? w_diff : -w_diff);

endmodule

// File: rtl/fp32_to_int32.sv
// Iterative fp32 -> int32 converter: one alignment bit per cycle, RNE rounding,
// saturation on overflow, valid/ready handshakes on both sides.
module fp32_to_int32
  import fp32_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned EWIDTH = fp32_pkg::EWIDTH,
  parameter int unsigned MWIDTH = fp32_pkg::MWIDTH,
  parameter int unsigned BIAS   = fp32_pkg::BIAS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] a_operand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              Exception,
  output logic              inexact
);

  cvt_state_t r_state, w_next;

  logic              w_sign, w_nan_inf, w_zd, w_ovf, w_int_min, w_small, w_dir;
  logic [EWIDTH-1:0] w_exp;
  logic [MWIDTH-1:0] w_man;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_accept, w_special, w_up;
  logic [31:0]       w_m2;

  logic [31:0]      r_mag;
  logic             r_guard, r_sticky, r_dir, r_sign;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_result;
  logic             r_exc, r_inexact;

  fp32_unpack #(
    .DWIDTH (DWIDTH),
    .P_EW   (EWIDTH),
    .P_MW   (MWIDTH),
    .P_BIAS (BIAS)
  ) u_unpack (
    .a_operand        (a_operand),
    .o_sign           (w_sign),
    .o_exp            (w_exp),
    .o_man            (w_man),
    .o_is_nan_inf     (w_nan_inf),
    .o_is_zero_denorm (w_zd),
    .o_is_ovf         (w_ovf),
    .o_is_int_min     (w_int_min),
    .o_is_small       (w_small),
    .o_cnt            (w_cnt),
    .o_dir            (w_dir)
  );

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_special = w_nan_inf || w_ovf || w_zd || w_small;
  assign w_up      = r_guard && (r_sticky || r_mag[0]);
  assign w_m2      = r_mag + {31'b0, w_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) w_next = w_special ? DONE : ((w_cnt == '0) ? ROUND : SHIFT);
      SHIFT: if (r_cnt == CNT_W'(1)) w_next = ROUND;
      ROUND: w_next = DONE;
      DONE:  if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag     <= '0;
      r_guard   <= 1'b0;
      r_sticky  <= 1'b0;
      r_dir     <= 1'b0;
      r_sign    <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_exc     <= 1'b0;
      r_inexact <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_sign <= w_sign;
          if (w_nan_inf) begin
            r_result  <= INT32_MIN;
            r_exc     <= 1'b1;
            r_inexact <= 1'b0;
          end else if (w_ovf) begin
            r_result  <= w_sign ? INT32_MIN : INT32_MAX;
            r_exc     <= !w_int_min;
            r_inexact <= 1'b0;
          end else if (w_zd || w_small) begin
            r_result  <= '0;
            r_exc     <= 1'b0;
            r_inexact <= |{w_exp, w_man};
          end else begin
            r_mag    <= 32'({1'b1, w_man});
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= w_cnt;
            r_dir    <= w_dir;
          end
        end
        // right shifts feed the discarded bits into guard/sticky for rounding
        SHIFT: begin
          if (r_dir) begin
            r_mag <= r_mag << 1;
          end else begin
            r_sticky <= r_sticky | r_guard;
            r_guard  <= r_mag[0];
            r_mag    <= r_mag >> 1;
          end
          r_cnt <= r_cnt - CNT_W'(1);
        end
        ROUND: begin
          r_result  <= r_sign ? -w_m2 : w_m2;
          r_inexact <= r_guard | r_sticky;
          r_exc     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign Exception = r_exc;
  assign inexact   = r_inexact;

endmodule

// File: doc/fp32_to_int32.md
# fp32_to_int32

Iterative IEEE-754 single-precision to signed 32-bit integer converter. It disassembles what the FPU's add/sub datapath assembles: it unpacks an fp32 operand, aligns the significand to the integer binary point one bit per cycle, and rounds to nearest-even. It sits on the FPU result path behind a valid/ready handshake and saturates on overflow. It flags out-of-range, infinity and NaN inputs through `Exception`, using the same meaning as the arithmetic units.

## Interface
- `DWIDTH`, 32: fp operand width
- `EWIDTH`, 8: exponent width
- `MWIDTH`, 23: stored mantissa width
- `BIAS`, 127: exponent bias
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  operand valid
- `in_ready`  out  1  converter idle, can accept
- `a_operand`  in  DWIDTH  fp32 input
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `result`  out  32  signed integer, two's complement
- `Exception`  out  1  NaN / infinity / out-of-range (saturated)
- `inexact`  out  1  nonzero fraction was discarded

## Operation
- Fields: sign `s`, exponent `E`, mantissa `M`; unbiased `e = E - BIAS` (signed, EWIDTH+2 bits).
- The state machine has four states: IDLE, SHIFT, ROUND, DONE.
- Capture occurs on accept (`in_valid & in_ready`, IDLE only). The block classifies the operand:
  - `E == 255` (inf or NaN): result 0x80000000, `Exception=1`, go to DONE.
  - `e >= 31`:
    - If `s=1`, `e=31`, `M=0`: result 0x80000000, `Exception=0`.
    - Otherwise saturate to 0x7FFFFFFF (`s=0`) or 0x80000000 (`s=1`) with `Exception=1`.
    - Go to DONE.
  - `E == 0` (zero or denormal) or `e <= -2`: result 0, `inexact = |{E,M}`, go to DONE.
  - Otherwise (normal): `mag = {1,M}` zero-extended to 32 bits. Clear `guard` and `sticky`. Set `cnt = |e-23|` and `dir = (e > 23)` (left). Go to SHIFT if `cnt != 0`, else to ROUND.
- SHIFT runs one bit per cycle and decrements `cnt`. It goes to ROUND when `cnt` reaches 1.
  - Left shift: `mag <<= 1`. At most 7 shifts (e=30), so `mag` stays under 2^31.
  - Right shift: `sticky <= sticky|guard`, `guard <= mag[0]`, `mag >>= 1`. At most 24 shifts (e=-1).
- ROUND is a single cycle:
  - `up = guard & (sticky | mag[0])`, `m2 = mag + up`.
  - `result = s ? -m2 : m2`, `inexact = guard|sticky`, `Exception = 0`.
  - Go to DONE. `m2` cannot exceed 2^31-1 for `e <= 30`.
- DONE: `out_valid=1`. `result`, `Exception` and `inexact` are held stable until `out_ready`, then the block returns to IDLE.

## Timing
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `result=0`, `Exception=0`, `inexact=0`, internal regs 0.
- `in_ready = (state == IDLE)`. There is no overlap of operations, and no accept occurs in the DONE cycle.
- Let the accept edge be k. Latency to the first `out_valid` cycle:
  - Special/zero/overflow: `out_valid` is high from k+1.
  - Normal: `out_valid` is high from k+2+|e-23|. Minimum 2 (e=23), maximum 26 (e=-1).
- Backpressure:
  - `out_valid` stays high and outputs stay frozen while `out_ready=0`.
  - The output handshake at edge j returns the block to IDLE, with `in_ready=1` from j+1.
- Outputs are registered. There is no combinational path from `a_operand` to `result`.
- `rst` asserted in any state: immediate return to IDLE with reset values. Any in-flight operand is discarded and no `out_valid` is produced for it.
- `in_valid` while not IDLE is ignored. Upstream must hold the operand until accepted.

## Structure
- Shared package `fp32_pkg`:
  - `BIAS`, `EWIDTH` and `MWIDTH` constants.
  - `INT32_MAX = 32'h7FFFFFFF` and `INT32_MIN = 32'h80000000`.
  - State enum `cvt_state_t` {IDLE, SHIFT, ROUND, DONE}.
- Sub-module `fp32_unpack` (combinational):
  - Splits `s`/`E`/`M`.
  - Computes `e`, `is_nan_inf`, `is_zero_denorm`, `is_ovf`, `is_int_min`, `is_small`, `cnt` and `dir`.
  - The top level holds the FSM, shifter, round and negate logic.

## Test plan
- 0x3F800000 (1.0): result 1, `Exception=0`, `inexact=0`, `out_valid` at k+25.
- 0x40200000 (2.5): result 2; 0x40600000 (3.5): result 4; 0xC0200000 (-2.5): result 0xFFFFFFFE. All with `inexact=1` (ties to even).
- 0x3F000000 (0.5): result 0, `inexact=1`, k+26. 0x3E800000 (0.25): result 0, `inexact=1`, k+1.
- 0xCF000000: 0x80000000 with `Exception=0`. 0x4F000000: 0x7FFFFFFF with `Exception=1`. 0x7FC00000 (NaN): 0x80000000 with `Exception=1`. All at k+1.
- 0x4EFFFFFF: result 0x7FFFFF80, k+9. Then hold `out_ready=0` for 5 cycles: `result` stable, `in_ready=0`, and a second `in_valid` is ignored.
- Assert `rst` in the middle of SHIFT on 0x3F800000: outputs go to reset values immediately, no `out_valid`, and the next operand converts correctly.
